exec_stage: RTL and testbench
=============================

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter REGAW, default 4, register address width.
REQ-002 SHALL have parameter REGDW, default 16, data width.
REQ-003 SHALL have port Clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port Rst_i, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port Start_i, input, 1, operation request; sampled only when Busy_o=0.
REQ-006 SHALL have port Op_i, input, 4, opcode.
REQ-007 SHALL have port RdAddr_i, input, REGAW, destination register address.
REQ-008 SHALL have port Rs1Data_i, input, REGDW, operand A from the register-file read port 1.
REQ-009 SHALL have port Rs2Data_i, input, REGDW, operand B from the register-file read port 2.
REQ-010 SHALL have port Busy_o, output, 1, high while an operation is in flight.
REQ-011 SHALL have port RegWEn_o, output, 1, one-cycle register-file write enable.
REQ-012 SHALL have port RdAddr_o, output, REGAW, write address, valid with RegWEn_o.
REQ-013 SHALL have port RdData_o, output, REGDW, write data, valid with RegWEn_o.
REQ-014 SHALL have port Zero_o, output, 1, high when the written result is all zeros; valid with RegWEn_o.
REQ-015 SHALL have port Err_o, output, 1, one-cycle pulse for an illegal opcode.

Function
REQ-016 SHALL use states IDLE, EXEC, MUL and WB.
REQ-017 SHALL, in IDLE with Start_i=1, register Op_i, RdAddr_i and both operands, assert Busy_o, and go to MUL when Op=8 (multiply compiled in), otherwise to EXEC.
REQ-018 SHALL ignore Start_i while Busy_o=1; no request is queued.
REQ-019 SHALL compute in EXEC: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT; then go to WB.
REQ-020 SHALL take the SLL/SRL shift amount from Rs2[3:0], with SRL zero-filling.
REQ-021 SHALL, for SLT, produce 1 when A<B as signed values, else 0.
REQ-022 SHALL wrap ADD and SUB modulo 2^REGDW with no carry or overflow output.
REQ-023 SHALL pulse Err_o in EXEC for opcodes 9-15, skip RegWEn_o, and return to IDLE.
REQ-024 SHALL, in MUL, run a 16-iteration shift-add multiply, one bit per cycle, keep the low REGDW bits of the product, then go to WB.
REQ-025 SHALL, in WB, hold RegWEn_o=1 for exactly one cycle with RdAddr_o, RdData_o and Zero_o valid, then go to IDLE with Busy_o=0.
REQ-026 SHALL give ALU ops latency Start-accept cycle N -> RegWEn_o at N+2, so the next Start is accepted at N+3.
REQ-027 SHALL give MUL latency N -> RegWEn_o at N+17.
REQ-028 SHALL treat address 0 as an ordinary register: writes to 0 are issued.
REQ-029 SHALL hold RdData_o and RdAddr_o at their last values outside WB.

Reset
REQ-030 SHALL, on Rst_i=1 at a clock edge, enter IDLE and clear Busy_o, RegWEn_o, RdAddr_o, RdData_o, Zero_o, Err_o and the multiplier state to 0.
REQ-031 SHALL let reset abort an in-flight operation, including mid-MUL, with no write issued.
REQ-032 SHALL give Rst_i priority over a simultaneous Start_i.

Configuration
REQ-033 SHALL, with macro EXEC_STAGE_MUL_EN defined, include the MUL state and the multiplier.
REQ-034 SHALL, without EXEC_STAGE_MUL_EN, omit the multiplier and treat opcode 8 as illegal (Err_o pulse, no write).

Structure
REQ-035 SHALL take the opcode encodings (localparams), the state encoding and the default REGAW/REGDW values from a shared package exec_pkg.
REQ-036 SHALL place the iterative multiplier in sub-module exec_mul (start/done handshake, 16-cycle), instantiated only under EXEC_STAGE_MUL_EN.

Verification
REQ-037 SHALL check ADD: Op=0, A=16'h7FFF, B=16'h0001, Rd=3 -> RegWEn_o at N+2, RdAddr_o=3, RdData_o=16'h8000, Zero_o=0.
REQ-038 SHALL check SUB: Op=1, A=16'h0005, B=16'h0005 -> RdData_o=0, Zero_o=1; SLT with A=16'hFFFF, B=1 -> RdData_o=1.
REQ-039 SHALL check MUL: Op=8, A=16'h0012, B=16'h0034 -> RegWEn_o at N+17, RdData_o=16'h03A8; Start_i pulsed at N+5 is ignored.
REQ-040 SHALL check illegal Op=4'hF -> Err_o pulse at N+1, RegWEn_o stays 0, Busy_o=0 at N+2.
REQ-041 SHALL check Rst_i=1 at N+8 during MUL -> all outputs 0 next cycle, no RegWEn_o pulse, and a new Start is accepted after release.
REQ-042 SHALL check with EXEC_STAGE_MUL_EN undefined: Op=8 -> Err_o pulse, no write.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared opcodes, state encoding and default widths for the execute stage
package exec_pkg;
    localparam int DEF_REGAW = 4;
    localparam int DEF_REGDW = 16;
    localparam int MUL_ITERS = 16;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;
endpackage

// File: rtl/exec_mul.sv
// exec_mul: 16-iteration shift-add multiplier, one multiplier bit per cycle, low REGDW bits kept
module exec_mul
    import exec_pkg::*;
#(
    parameter int REGDW = DEF_REGDW
) (
    input  logic             Clk_i,
    input  logic             Rst_i,
    input  logic             Start_i,
    input  logic [REGDW-1:0] A_i,
    input  logic [REGDW-1:0] B_i,
    output logic             Done_o,
    output logic [REGDW-1:0] Result_o
);
    logic [REGDW-1:0] acc, mcand, mplier, step;
    logic [3:0] cnt;
    logic run;
    assign step = acc + (mplier[0] ? mcand : '0);
    assign Done_o = run && cnt == 4'(MUL_ITERS - 1);
    assign Result_o = step;
    // load operands on start, then add-and-shift once per cycle; the last step is forwarded combinationally
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (Start_i) begin
            acc <= '0;
            mcand <= A_i;
            mplier <= B_i;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            acc <= step;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + 4'd1;
            run <= !Done_o;
        end
    end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: single-issue execute stage (ALU + optional multiplier, enabled by EXEC_STAGE_MUL_EN)
module exec_stage
    import exec_pkg::*;
#(
    parameter int REGAW = DEF_REGAW,
    parameter int REGDW = DEF_REGDW
) (
    input  logic             Clk_i,
    input  logic             Rst_i,
    input  logic             Start_i,
    input  logic [3:0]       Op_i,
    input  logic [REGAW-1:0] RdAddr_i,
    input  logic [REGDW-1:0] Rs1Data_i,
    input  logic [REGDW-1:0] Rs2Data_i,
    output logic             Busy_o,
    output logic             RegWEn_o,
    output logic [REGAW-1:0] RdAddr_o,
    output logic [REGDW-1:0] RdData_o,
    output logic             Zero_o,
    output logic             Err_o
);
    state_t state, state_d;
    logic [3:0] op_q;
    logic [REGAW-1:0] rd_q;
    logic [REGDW-1:0] a_q, b_q, alu_res, wb_data, mul_res;
    logic mul_done, legal, accept;
    assign accept = state == S_IDLE && Start_i;
`ifdef EXEC_STAGE_MUL_EN
    localparam bit MUL_EN = 1'b1;
    exec_mul #(.REGDW(REGDW)) u_mul (
        .Clk_i(Clk_i),
        .Rst_i(Rst_i),
        .Start_i(accept && Op_i == OP_MUL),
        .A_i(Rs1Data_i),
        .B_i(Rs2Data_i),
        .Done_o(mul_done),
        .Result_o(mul_res)
    );
`else
    localparam bit MUL_EN = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res = '0;
`endif
    assign legal = op_q <= OP_SLT;
    assign wb_data = state == S_MUL ? mul_res : alu_res;
    assign Busy_o = state != S_IDLE;
    assign RegWEn_o = state == S_WB;
    assign Err_o = state == S_EXEC && !legal;
    // single-cycle ALU on the captured operands; shifts use only the low four bits of B
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD: alu_res = a_q + b_q;
            OP_SUB: alu_res = a_q - b_q;
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SLL: alu_res = a_q << b_q[3:0];
            OP_SRL: alu_res = a_q >> b_q[3:0];
            OP_SLT: alu_res = REGDW'($signed(a_q) < $signed(b_q));
            default: alu_res = '0;
        endcase
    end
    // next state: illegal opcodes fall back to IDLE from EXEC without a write
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: state_d = Start_i ? ((MUL_EN && Op_i == OP_MUL) ? S_MUL : S_EXEC) : S_IDLE;
            S_EXEC: state_d = legal ? S_WB : S_IDLE;
            S_MUL:  state_d = mul_done ? S_WB : S_MUL;
            default: state_d = S_IDLE;
        endcase
    end
    // state register, request capture, and write-back registers that hold between writes
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state <= S_IDLE;
            op_q <= '0;
            rd_q <= '0;
            a_q <= '0;
            b_q <= '0;
            RdAddr_o <= '0;
            RdData_o <= '0;
            Zero_o <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                op_q <= Op_i;
                rd_q <= RdAddr_i;
                a_q <= Rs1Data_i;
                b_q <= Rs2Data_i;
            end
            if (state != S_WB && state_d == S_WB) begin
                RdAddr_o <= rd_q;
                RdData_o <= wb_data;
                Zero_o <= wb_data == '0;
            end
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed bench with a timeline model of the execute stage checked every cycle
module tb_exec_stage;
`ifdef EXEC_STAGE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic Clk_i = 1'b0, Rst_i = 1'b1, Start_i = 1'b0;
    logic [3:0] Op_i = '0, RdAddr_i = '0, RdAddr_o;
    logic [15:0] Rs1Data_i = '0, Rs2Data_i = '0, RdData_o;
    logic Busy_o, RegWEn_o, Zero_o, Err_o;
    int cyc = 0, checks = 0, failures = 0;

    exec_stage dut (
        .Clk_i(Clk_i), .Rst_i(Rst_i), .Start_i(Start_i), .Op_i(Op_i), .RdAddr_i(RdAddr_i),
        .Rs1Data_i(Rs1Data_i), .Rs2Data_i(Rs2Data_i), .Busy_o(Busy_o), .RegWEn_o(RegWEn_o),
        .RdAddr_o(RdAddr_o), .RdData_o(RdData_o), .Zero_o(Zero_o), .Err_o(Err_o)
    );

    always #5 Clk_i = ~Clk_i;
    always @(posedge Clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // {legal, result} straight from the opcode table
    function automatic logic [16:0] model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0: return {1'b1, 16'(a + b)};
            4'd1: return {1'b1, 16'(a - b)};
            4'd2: return {1'b1, a & b};
            4'd3: return {1'b1, a | b};
            4'd4: return {1'b1, a ^ b};
            4'd5: return {1'b1, 16'(a << b[3:0])};
            4'd6: return {1'b1, 16'(a >> b[3:0])};
            4'd7: return {1'b1, 15'h0, $signed(a) < $signed(b)};
            4'd8: return MUL_EN ? {1'b1, 16'(a * b)} : 17'h0;
            default: return 17'h0;
        endcase
    endfunction

    // timeline model: accepted request at cycle N schedules a write at N+latency or an error at N+1
    bit seen_rst = 0;
    int wb_cyc = -1, err_cyc = -1, free_cyc = 0;
    logic [15:0] pend_d, last_d;
    logic [3:0] pend_a, last_a;
    logic pend_z, last_z;
    logic [16:0] r;
    always @(negedge Clk_i) begin
        if (seen_rst) begin
            if (cyc == wb_cyc) begin
                last_d = pend_d;
                last_a = pend_a;
                last_z = pend_z;
            end
            chk("busy", Busy_o, cyc < free_cyc);
            chk("regwen", RegWEn_o, cyc == wb_cyc);
            chk("err", Err_o, cyc == err_cyc);
            chk("rd_addr", RdAddr_o, last_a);
            chk("rd_data", RdData_o, last_d);
            chk("zero", Zero_o, last_z);
        end
        if (Rst_i) begin
            seen_rst = 1;
            wb_cyc = -1;
            err_cyc = -1;
            free_cyc = cyc + 1;
            last_d = '0;
            last_a = '0;
            last_z = 1'b0;
        end else if (seen_rst && Start_i && cyc >= free_cyc) begin
            r = model_op(Op_i, Rs1Data_i, Rs2Data_i);
            if (r[16]) begin
                wb_cyc = cyc + ((Op_i == 4'd8) ? 17 : 2);
                free_cyc = wb_cyc + 1;
                pend_d = r[15:0];
                pend_a = RdAddr_i;
                pend_z = r[15:0] == 16'h0;
            end else begin
                err_cyc = cyc + 1;
                free_cyc = cyc + 2;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [15:0] a, input logic [15:0] b, output int n);
        @(posedge Clk_i); #1;
        Start_i = 1'b1; Op_i = op; RdAddr_i = rd; Rs1Data_i = a; Rs2Data_i = b;
        n = cyc;
        @(posedge Clk_i); #1;
        Start_i = 1'b0;
    endtask

    task automatic at_cycle(input int t);
        do @(negedge Clk_i); while (cyc < t);
    endtask

    typedef struct { logic [3:0] op; logic [15:0] a, b, exp; } vec_t;
    vec_t vecs[11] = '{
        '{4'd1, 16'h0005, 16'h0005, 16'h0000},
        '{4'd2, 16'hF0F0, 16'h3C3C, 16'h3030},
        '{4'd3, 16'hF0F0, 16'h0F0F, 16'hFFFF},
        '{4'd4, 16'hAAAA, 16'hFFFF, 16'h5555},
        '{4'd5, 16'h0001, 16'h00F3, 16'h0008},
        '{4'd6, 16'h8000, 16'h0004, 16'h0800},
        '{4'd7, 16'hFFFF, 16'h0001, 16'h0001},
        '{4'd7, 16'h0001, 16'hFFFF, 16'h0000},
        '{4'd0, 16'hFFFF, 16'h0001, 16'h0000},
        '{4'd1, 16'h0000, 16'h0001, 16'hFFFF},
        '{4'd0, 16'h1234, 16'h4321, 16'h5555}
    };

    initial begin
        int n, rc, wcount;
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rc, wcount;
        repeat (2) begin @(posedge Clk_i); #1; end
        Rst_i = 1'b0;
        at_cycle(cyc);
        chk("rst_busy", Busy_o, 0);
        chk("rst_regwen", RegWEn_o, 0);
        chk("rst_err", Err_o, 0);
        chk("rst_data", RdData_o, 0);
        chk("rst_addr", RdAddr_o, 0);
        chk("rst_zero", Zero_o, 0);
        // ADD with signed overflow wraps; a Start during the busy cycle is dropped
        issue(4'd0, 4'd3, 16'h7FFF, 16'h0001, n);
        Start_i = 1'b1; Op_i = 4'hF;
        at_cycle(n + 1);
        chk("add_n1_regwen", RegWEn_o, 0);
        @(posedge Clk_i); #1;
        Start_i = 1'b0;
        at_cycle(n + 2);
        chk("add_regwen", RegWEn_o, 1);
        chk("add_addr", RdAddr_o, 4'd3);
        chk("add_data", RdData_o, 16'h8000);
        chk("add_zero", Zero_o, 0);
        chk("add_noerr", Err_o, 0);
        at_cycle(n + 3);
        chk("add_idle", Busy_o, 0);
        chk("add_hold", RdData_o, 16'h8000);
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, 4'(i), vecs[i].a, vecs[i].b, n);
            at_cycle(n + 2);
            chk($sformatf("alu%0d_regwen", i), RegWEn_o, 1);
            chk($sformatf("alu%0d_data", i), RdData_o, vecs[i].exp);
            chk($sformatf("alu%0d_addr", i), RdAddr_o, i);
            chk($sformatf("alu%0d_zero", i), Zero_o, vecs[i].exp == 16'h0);
        end
        issue(4'hF, 4'd2, 16'h0001, 16'h0001, n);
        at_cycle(n + 1);
        chk("ill_err", Err_o, 1);
        chk("ill_regwen", RegWEn_o, 0);
        at_cycle(n + 2);
        chk("ill_busy", Busy_o, 0);
        chk("ill_regwen2", RegWEn_o, 0);
        issue(4'd8, 4'd5, 16'h0012, 16'h0034, n);
        if (MUL_EN) begin
            at_cycle(n + 4);
            @(posedge Clk_i); #1;
            Start_i = 1'b1; Op_i = 4'd0; Rs1Data_i = 16'h0001; Rs2Data_i = 16'h0001;
            @(posedge Clk_i); #1;
            Start_i = 1'b0;
            at_cycle(n + 16);
            chk("mul_n16_regwen", RegWEn_o, 0);
            chk("mul_n16_busy", Busy_o, 1);
            at_cycle(n + 17);
            chk("mul_regwen", RegWEn_o, 1);
            chk("mul_data", RdData_o, 16'h03A8);
            chk("mul_addr", RdAddr_o, 4'd5);
            at_cycle(n + 18);
            chk("mul_idle", Busy_o, 0);
        end else begin
            at_cycle(n + 1);
            chk("mul_off_err", Err_o, 1);
            chk("mul_off_regwen", RegWEn_o, 0);
            at_cycle(n + 2);
            chk("mul_off_busy", Busy_o, 0);
            chk("mul_off_regwen2", RegWEn_o, 0);
        end
        // reset mid-operation with a simultaneous Start: nothing is written and the next request works
        issue(MUL_EN ? 4'd8 : 4'd0, 4'd9, 16'h0003, 16'h0004, n);
        rc = MUL_EN ? n + 8 : n + 1;
        while (cyc < rc) begin @(posedge Clk_i); #1; end
        Rst_i = 1'b1; Start_i = 1'b1; Op_i = 4'd0;
        @(posedge Clk_i); #1;
        Rst_i = 1'b0; Start_i = 1'b0;
        at_cycle(rc + 1);
        chk("abort_busy", Busy_o, 0);
        chk("abort_regwen", RegWEn_o, 0);
        chk("abort_err", Err_o, 0);
        chk("abort_data", RdData_o, 0);
        chk("abort_addr", RdAddr_o, 0);
        chk("abort_zero", Zero_o, 0);
        wcount = 0;
        while (cyc < n + 20) begin
            at_cycle(cyc + 1);
            if (RegWEn_o === 1'b1) wcount++;
        end
        chk("abort_nowrite", wcount, 0);
        issue(4'd0, 4'd7, 16'h0002, 16'h0003, n);
        at_cycle(n + 2);
        chk("post_rst_regwen", RegWEn_o, 1);
        chk("post_rst_data", RdData_o, 16'h0005);
        chk("post_rst_addr", RdAddr_o, 4'd7);
        at_cycle(cyc + 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
